vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 clock_25mhz  input  1  pixel clock, rising-edge active; sole clock of the block.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  count-enable; when low, all state holds.
REQ-005 pixel_x  output  10  current horizontal count, 0..799.
REQ-006 pixel_y  output  10  current vertical count, 0..524.
REQ-007 hsync  output  1  horizontal sync, active low.
REQ-008 vsync  output  1  vertical sync, active low.
REQ-009 video_on  output  1  high when the pixel is inside the 640x480 visible area.
REQ-010 line_end  output  1  high on the last pixel of each line.
REQ-011 frame_end  output  1  high on the last pixel of each frame.
REQ-012 frame_count  output  8  number of completed frames, modulo 256.

Function
REQ-013 Horizontal timing SHALL be fixed at 640 visible, 16 front porch, 96 sync and 48 back porch, for a total of 800 pixels.
REQ-014 Vertical timing SHALL be fixed at 480 visible, 10 front porch, 2 sync and 33 back porch, for a total of 525 lines.
REQ-015 On each rising edge with enable=1 and reset=0, pixel_x SHALL increment by 1.
REQ-016 pixel_x SHALL wrap from 799 to 0.
REQ-017 pixel_y SHALL increment by 1 only on the edge where pixel_x wraps from 799 to 0.
REQ-018 pixel_y SHALL wrap from 524 to 0 on the edge where pixel_x wraps and pixel_y=524.
REQ-019 With enable=0, pixel_x, pixel_y, frame_count and all sync outputs SHALL hold their values.
REQ-020 With enable=0, line_end and frame_end SHALL hold their decoded values; they still decode the held counts.
REQ-021 All outputs SHALL be driven from registers; no combinational path SHALL exist from any input to any output.
REQ-022 Every output SHALL be consistent with the pixel_x/pixel_y values shown in the same cycle, with zero skew between them. Sync and flag registers are loaded from decoded next-count values.
REQ-023 hsync SHALL be 0 iff 656 <= pixel_x <= 751.
REQ-024 vsync SHALL be 0 iff 490 <= pixel_y <= 491.
REQ-025 video_on SHALL be 1 iff pixel_x <= 639 and pixel_y <= 479.
REQ-026 line_end SHALL be 1 iff pixel_x = 799.
REQ-027 frame_end SHALL be 1 iff pixel_x = 799 and pixel_y = 524.
REQ-028 frame_count SHALL increment by 1 on the edge where the counts wrap from (799,524) to (0,0).
REQ-029 frame_count SHALL wrap from 255 to 0 without saturating.
REQ-030 Count comparisons SHALL be unsigned at 10 bits.
REQ-031 Counts outside the legal ranges SHALL be unreachable.
REQ-032 Any state decoding as pixel_x > 799 or pixel_y > 524 SHALL recover to 0 on the next enabled edge.

Reset
REQ-033 reset=1 at a rising edge SHALL set the following values, regardless of enable: pixel_x=0, pixel_y=0, frame_count=0, hsync=1, vsync=1, video_on=1, line_end=0, frame_end=0.
REQ-034 Reset SHALL take priority over enable and over any wrap condition.
REQ-035 Reset asserted mid-line or mid-frame SHALL abandon the frame; frame_count SHALL NOT increment for the abandoned frame.
REQ-036 The first enabled edge after reset deasserts SHALL advance pixel_x to 1.

Verification
REQ-037 Reset, then 800 enabled cycles -> the following SHALL be observed:
- line_end=1 exactly at pixel_x=799.
- pixel_x then shows 0 and pixel_y shows 1.
- hsync is low for exactly 96 cycles, starting at pixel_x=656.
REQ-038 Reset, then 420000 enabled cycles -> the following SHALL be observed:
- frame_end=1 exactly once, at (799,524).
- frame_count goes 0 -> 1 at the return to (0,0).
- vsync is low for exactly 1600 cycles, over lines 490-491.
- video_on is high for exactly 307200 cycles.
REQ-039 Toggle enable low for 5 cycles at pixel_x=798, pixel_y=524 -> the following SHALL be observed:
- all outputs frozen for those 5 cycles.
- frame_end is high only while pixel_x=799.
- the wrap occurs exactly once.
REQ-040 Assert reset at (700,300) -> the following SHALL be observed:
- next cycle shows (0,0), hsync=1, vsync=1, video_on=1.
- frame_count=0.
REQ-041 Run 256 full frames -> frame_count SHALL wrap from 255 to 0 with no extra pulses.
REQ-042 Apply reset and enable high simultaneously -> reset SHALL win, and the counts SHALL stay at (0,0) while reset is held.

Source files
------------

// File: rtl/vga_sync_gen_if.sv
// VGA sync generator bundle.
// Count-enable in, registered timing outputs back.
interface vga_sync_gen_if;
  logic       enable;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_end;
  logic       frame_end;
  logic [7:0] frame_count;

  modport master (
    input  enable,
    output pixel_x,
    output pixel_y,
    output hsync,
    output vsync,
    output video_on,
    output line_end,
    output frame_end,
    output frame_count
  );

  modport slave (
    output enable,
    input  pixel_x,
    input  pixel_y,
    input  hsync,
    input  vsync,
    input  video_on,
    input  line_end,
    input  frame_end,
    input  frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480 VGA timing generator.
// All outputs registered, decoded from the next counts.
module vga_sync_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic           clock_25mhz,
  input  logic           reset,
  vga_sync_gen_if.master bus
);

  localparam int unsigned H_TOT =
    H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT =
    V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS - 1);
  localparam logic [9:0] V_VEND = 10'(V_VIS - 1);
  localparam logic [9:0] H_SS   = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SE   =
    10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SE   =
    10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] fc_q, fc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       von_q, von_d;
  logic       le_q, le_d;
  logic       fe_q, fe_d;

  // Next counts; out-of-range values fall back to zero.
  always_comb begin
    x_d  = x_q + 10'd1;
    y_d  = y_q;
    fc_d = fc_q;
    if (y_q > V_LAST)
      y_d = '0;
    if (x_q >= H_LAST) begin
      x_d = '0;
      if (y_q >= V_LAST) begin
        y_d = '0;
        if (x_q == H_LAST && y_q == V_LAST)
          fc_d = fc_q + 8'd1;
      end else begin
        y_d = y_q + 10'd1;
      end
    end
  end

  // Decode timing flags from the next counts.
  always_comb begin
    hs_d  = !(x_d >= H_SS && x_d <= H_SE);
    vs_d  = !(y_d >= V_SS && y_d <= V_SE);
    von_d = (x_d <= H_VEND) && (y_d <= V_VEND);
    le_d  = (x_d == H_LAST);
    fe_d  = (x_d == H_LAST) && (y_d == V_LAST);
  end

  // State update; reset beats enable, disable holds all.
  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      fc_q  <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      von_q <= 1'b1;
      le_q  <= 1'b0;
      fe_q  <= 1'b0;
    end else if (bus.enable) begin
      x_q   <= x_d;
      y_q   <= y_d;
      fc_q  <= fc_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      le_q  <= le_d;
      fe_q  <= fe_d;
    end
  end

  assign bus.pixel_x     = x_q;
  assign bus.pixel_y     = y_q;
  assign bus.frame_count = fc_q;
  assign bus.hsync       = hs_q;
  assign bus.vsync       = vs_q;
  assign bus.video_on    = von_q;
  assign bus.line_end    = le_q;
  assign bus.frame_end   = fe_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size and shrunk timing.
// Expected outputs queued per edge, compared at negedge.
module tb_vga_sync_gen;

  typedef struct {
    int x;
    int y;
    int fc;
  } cnt_t;

  logic clk;
  logic rst;

  vga_sync_gen_if if_f ();
  vga_sync_gen_if if_s ();

  vga_sync_gen u_full (
    .clock_25mhz (clk),
    .reset       (rst),
    .bus         (if_f)
  );

  vga_sync_gen #(
    .H_VIS  (8),
    .H_FP   (2),
    .H_SYNC (3),
    .H_BP   (2),
    .V_VIS  (4),
    .V_FP   (1),
    .V_SYNC (2),
    .V_BP   (1)
  ) u_small (
    .clock_25mhz (clk),
    .reset       (rst),
    .bus         (if_s)
  );

  int nchk = 0;
  int nerr = 0;

  logic [32:0] qf[$];
  logic [32:0] qs[$];

  cnt_t mf;
  cnt_t ms;

  int f_hslow, f_hsfirst, f_le;
  int s_vslow, s_von, s_fe, s_fcinc, s_wrap;
  int s_fcprev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic cmpv(input string nm,
                      input logic [32:0] act,
                      input logic [32:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic cnt_t nxt(input cnt_t c,
                               input int ht,
                               input int vt,
                               input logic r,
                               input logic e);
    cnt_t n;
    n = c;
    if (r) begin
      n.x = 0;
      n.y = 0;
      n.fc = 0;
    end else if (e) begin
      if (c.x == ht - 1) begin
        n.x = 0;
        if (c.y == vt - 1) begin
          n.y = 0;
          n.fc = (c.fc + 1) % 256;
        end else begin
          n.y = c.y + 1;
        end
      end else begin
        n.x = c.x + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [32:0] expv(
    input cnt_t c,
    input int hv, input int hf,
    input int hs, input int hb,
    input int vv, input int vf,
    input int vs, input int vb);
    logic hso, vso, von, le, fe;
    int ht, vt;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    hso = !(c.x >= hv + hf && c.x < hv + hf + hs);
    vso = !(c.y >= vv + vf && c.y < vv + vf + vs);
    von = (c.x < hv) && (c.y < vv);
    le  = (c.x == ht - 1);
    fe  = le && (c.y == vt - 1);
    return {10'(c.x), 10'(c.y), hso, vso,
            von, le, fe, 8'(c.fc)};
  endfunction

  function automatic logic [32:0] actf();
    return {if_f.pixel_x, if_f.pixel_y,
            if_f.hsync, if_f.vsync,
            if_f.video_on, if_f.line_end,
            if_f.frame_end, if_f.frame_count};
  endfunction

  function automatic logic [32:0] acts();
    return {if_s.pixel_x, if_s.pixel_y,
            if_s.hsync, if_s.vsync,
            if_s.video_on, if_s.line_end,
            if_s.frame_end, if_s.frame_count};
  endfunction

  task automatic clr_stats();
    f_hslow   = 0;
    f_hsfirst = -1;
    f_le      = 0;
    s_vslow   = 0;
    s_von     = 0;
    s_fe      = 0;
    s_fcinc   = 0;
    s_wrap    = 0;
    s_fcprev  = int'(if_s.frame_count);
  endtask

  // One clock: drive inputs, advance models, queue
  // expectations, then gather run statistics.
  task automatic step(input logic r, input logic e);
    int fc;
    rst = r;
    if_f.enable = e;
    if_s.enable = e;
    @(posedge clk);
    mf = nxt(mf, 800, 525, r, e);
    ms = nxt(ms, 15, 8, r, e);
    qf.push_back(expv(mf, 640, 16, 96, 48,
                      480, 10, 2, 33));
    qs.push_back(expv(ms, 8, 2, 3, 2,
                      4, 1, 2, 1));
    #2;
    if (!if_f.hsync) begin
      f_hslow++;
      if (f_hsfirst < 0)
        f_hsfirst = int'(if_f.pixel_x);
    end
    if (if_f.line_end) f_le++;
    if (!if_s.vsync) s_vslow++;
    if (if_s.video_on) s_von++;
    if (if_s.frame_end) s_fe++;
    fc = int'(if_s.frame_count);
    if (fc != s_fcprev) s_fcinc++;
    if (s_fcprev == 255 && fc == 0) s_wrap++;
    s_fcprev = fc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (qf.size() > 0)
      cmpv("full_outputs", actf(), qf.pop_front());
    if (qs.size() > 0)
      cmpv("small_outputs", acts(), qs.pop_front());
  end

  initial begin
    mf = '{0, 0, 0};
    ms = '{0, 0, 0};
    rst = 1'b1;
    if_f.enable = 1'b0;
    if_s.enable = 1'b0;

    // Reset with enable low, then with enable high.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_x", int'(if_f.pixel_x), 0);
    chk("reset_hsync", int'(if_f.hsync), 1);
    chk("reset_video_on", int'(if_f.video_on), 1);

    // One small frame: flag totals.
    clr_stats();
    step(1'b0, 1'b1);
    chk("first_edge_x", int'(if_f.pixel_x), 1);
    run(119);
    chk("s_video_on_cnt", s_von, 32);
    chk("s_vsync_low_cnt", s_vslow, 30);
    chk("s_frame_end_cnt", s_fe, 1);
    chk("s_frame_count", int'(if_s.frame_count), 1);

    // One full line.
    step(1'b1, 1'b1);
    clr_stats();
    run(799);
    chk("f_line_end_799", int'(if_f.line_end), 1);
    chk("f_x_799", int'(if_f.pixel_x), 799);
    step(1'b0, 1'b1);
    chk("f_hsync_low_cnt", f_hslow, 96);
    chk("f_hsync_first_x", f_hsfirst, 656);
    chk("f_line_end_cnt", f_le, 1);
    chk("f_wrap_x", int'(if_f.pixel_x), 0);
    chk("f_wrap_y", int'(if_f.pixel_y), 1);

    // Freeze around the end of a small frame.
    step(1'b1, 1'b1);
    run(118);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0);
    chk("hold_x", int'(if_s.pixel_x), 13);
    chk("hold_y", int'(if_s.pixel_y), 7);
    step(1'b0, 1'b1);
    chk("fe_at_last", int'(if_s.frame_end), 1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0);
    chk("fe_held", int'(if_s.frame_end), 1);
    chk("fc_held", int'(if_s.frame_count), 0);
    step(1'b0, 1'b1);
    chk("hold_wrap_x", int'(if_s.pixel_x), 0);
    chk("hold_wrap_fc", int'(if_s.frame_count), 1);

    // Reset mid-line, mid-frame.
    step(1'b1, 1'b1);
    run(700);
    chk("mid_x", int'(if_f.pixel_x), 700);
    chk("mid_hsync", int'(if_f.hsync), 0);
    chk("mid_s_fc", int'(if_s.frame_count), 5);
    step(1'b1, 1'b1);
    chk("abort_x", int'(if_f.pixel_x), 0);
    chk("abort_hsync", int'(if_f.hsync), 1);
    chk("abort_video_on", int'(if_f.video_on), 1);
    chk("abort_s_fc", int'(if_s.frame_count), 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk("held_reset_x", int'(if_f.pixel_x), 0);

    // 256 small frames: frame_count wrap.
    step(1'b1, 1'b1);
    clr_stats();
    run(255 * 120);
    chk("fc_255", int'(if_s.frame_count), 255);
    run(120);
    chk("fc_wrap0", int'(if_s.frame_count), 0);
    chk("fc_steps", s_fcinc, 256);
    chk("fc_wraps", s_wrap, 1);
    chk("fe_pulses", s_fe, 256);

    // Random enable with sparse resets.
    for (int i = 0; i < 1500; i++)
      step(($urandom % 64) == 0,
           ($urandom % 2) == 1);

    @(negedge clk);
    #1;
    chk("queue_drained", qf.size() + qs.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
